// File: rtl/fft16_out_unloader.sv
// Reorders digit-reversed radix-4 stage-2 output beats into natural-order bins using two frame banks.
// Define FFT16_UNLOAD_SOP_CHECK_EN to add the in_sop framing check with a sticky err_sop flag.
module fft16_out_unloader #(
  parameter int DW = 17,
  parameter int NB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_data,
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
  input  logic            in_sop,
  output logic            err_sop,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [3:0]      out_idx,
  output logic            out_last
);

  localparam int WW = 2 * DW;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  logic [WW-1:0] mem_q [NB*16];
  logic [WW-1:0] lane_word [4];

  bank_state_e state_q [NB];
  bank_state_e state_d [NB];
  logic        wbank_q, wbank_d;
  logic        rbank_q, rbank_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [DW-1:0] out_re_q, out_re_d;
  logic [DW-1:0] out_im_q, out_im_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic        out_last_q, out_last_d;
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
  logic        err_sop_q, err_sop_d;
`endif

  logic          wr_fire;
  logic          rd_fire;
  logic          do_store;
  logic [1:0]    beat_idx;
  logic [WW-1:0] rd_word;

  // Lane gi of a beat carries bin beat_idx + 4*gi, most significant lane first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_word[gi] = in_data[8*DW-1-WW*gi -: WW];
    end
  endgenerate

  always_comb begin
    wr_fire = in_valid & in_ready_q;
    rd_fire = out_valid_q & out_ready;

    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
    end
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    do_store = wr_fire;
    beat_idx = wcnt_q;
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
    err_sop_d = err_sop_q;
    if (wr_fire && in_sop && (wcnt_q != 2'd0)) begin
      beat_idx  = 2'd0;
      err_sop_d = 1'b1;
    end
    if (wr_fire && !in_sop && (wcnt_q == 2'd0)) begin
      do_store  = 1'b0;
      err_sop_d = 1'b1;
    end
`endif

    if (do_store) begin
      if (beat_idx == 2'd3) begin
        state_d[wbank_q] = BANK_FULL;
        wcnt_d           = 2'd0;
        wbank_d          = ~wbank_q;
      end else begin
        state_d[wbank_q] = BANK_FILLING;
        wcnt_d           = beat_idx + 2'd1;
      end
    end

    // Reads only touch FULL/DRAINING banks and writes only EMPTY/FILLING ones, so they never collide.
    if (rd_fire) begin
      if (rcnt_q == 4'd15) begin
        state_d[rbank_q] = BANK_EMPTY;
        rcnt_d           = 4'd0;
        rbank_d          = ~rbank_q;
      end else begin
        state_d[rbank_q] = BANK_DRAINING;
        rcnt_d           = rcnt_q + 4'd1;
      end
    end

    in_ready_d  = (state_d[wbank_d] == BANK_EMPTY) || (state_d[wbank_d] == BANK_FILLING);
    out_valid_d = (state_d[rbank_d] == BANK_FULL) || (state_d[rbank_d] == BANK_DRAINING);

    rd_word  = mem_q[{rbank_d, rcnt_d}];
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (out_valid_d) begin
      out_re_d = rd_word[WW-1:DW];
      out_im_d = rd_word[DW-1:0];
    end
    out_idx_d  = rcnt_d;
    out_last_d = out_valid_d && (rcnt_d == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int j = 0; j < 4; j++) begin
        mem_q[{wbank_q, 2'(j), beat_idx}] <= lane_word[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= BANK_EMPTY;
      end
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= 2'd0;
      rcnt_q      <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= 4'd0;
      out_last_q  <= 1'b0;
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
      err_sop_q   <= 1'b0;
`endif
    end else begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
      end
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
      err_sop_q   <= err_sop_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
`ifdef FFT16_UNLOAD_SOP_CHECK_EN
  assign err_sop   = err_sop_q;
`endif

endmodule
